// File: rtl/tap_pkg.sv
// Shared types and constants for the debug-port TAP controller.
package tap_pkg;

   localparam int unsigned IR_WIDTH            = 4;
   localparam int unsigned IDCODE_WIDTH        = 32;
   localparam int unsigned globalAddress_width = 32;
   localparam int unsigned data_width          = 64;

   typedef enum logic [3:0] {
      TEST_LOGIC_RESET = 4'd0,
      RUN_IDLE         = 4'd1,
      SELECT_DR        = 4'd2,
      CAPTURE_DR       = 4'd3,
      SHIFT_DR         = 4'd4,
      EXIT1_DR         = 4'd5,
      PAUSE_DR         = 4'd6,
      EXIT2_DR         = 4'd7,
      UPDATE_DR        = 4'd8,
      SELECT_IR        = 4'd9,
      CAPTURE_IR       = 4'd10,
      SHIFT_IR         = 4'd11,
      EXIT1_IR         = 4'd12,
      PAUSE_IR         = 4'd13,
      EXIT2_IR         = 4'd14,
      UPDATE_IR        = 4'd15
   } tap_state_t;

   localparam logic [IR_WIDTH-1:0] IDCODE     = 4'b0001;
   localparam logic [IR_WIDTH-1:0] LOAD       = 4'b0010;
   localparam logic [IR_WIDTH-1:0] BYPASS     = 4'b1111;
   localparam logic [IR_WIDTH-1:0] IR_CAPTURE = 4'b0101;

   // Payload held by the downstream 96-bit load data register.
   typedef struct packed {
      logic [globalAddress_width-1:0] addr;
      logic [data_width-1:0]          data;
   } load_word_t;

   typedef enum logic [1:0] {
      SEL_IDCODE = 2'd0,
      SEL_LOAD   = 2'd1,
      SEL_BYPASS = 2'd2
   } dr_sel_t;

   // Unrecognised instruction codes fall back to the bypass path.
   function automatic dr_sel_t decode_ir(input logic [IR_WIDTH-1:0] code);
      case (code)
         IDCODE:  return SEL_IDCODE;
         LOAD:    return SEL_LOAD;
         default: return SEL_BYPASS;
      endcase
   endfunction

endpackage

// File: rtl/tap_ir.sv
// Instruction register: capture/shift stage plus the active instruction latch.
module tap_ir
   import tap_pkg::*;
(
   input  logic                tck_i,
   input  logic                trst_i,
   input  tap_state_t          state,
   input  logic                tdi_i,
   output logic [IR_WIDTH-1:0] ir,
   output logic                ir_tdo,
   output logic                load_active
);

   logic [IR_WIDTH-1:0] ir_shift;

   // Shift stage; partially shifted data is simply lost on reset.
   always_ff @(posedge tck_i or posedge trst_i) begin
      if (trst_i) begin
         ir_shift <= '0;
      end else if (state == CAPTURE_IR) begin
         ir_shift <= IR_CAPTURE;
      end else if (state == SHIFT_IR) begin
         ir_shift <= {tdi_i, ir_shift[IR_WIDTH-1:1]};
      end
   end

   // Active instruction; load_active is kept alongside so drEna is a flop output.
   always_ff @(posedge tck_i or posedge trst_i) begin
      if (trst_i) begin
         ir          <= IDCODE;
         load_active <= 1'b0;
      end else if (state == TEST_LOGIC_RESET) begin
         ir          <= IDCODE;
         load_active <= 1'b0;
      end else if (state == UPDATE_IR) begin
         ir          <= ir_shift;
         load_active <= (decode_ir(ir_shift) == SEL_LOAD);
      end
   end

   assign ir_tdo = ir_shift[0];

endmodule

// File: rtl/tap_controller.sv
// IEEE 1149.1-style TAP: state machine, IDCODE/BYPASS registers and TDO mux
// in front of the 96-bit load data register.
module tap_controller
   import tap_pkg::*;
#(
   parameter logic [IDCODE_WIDTH-1:0] IDCODE_VALUE = 32'h0000_1A5F
)(
   input  logic       tck_i,
   input  logic       trst_i,
   input  logic       tms_i,
   input  logic       tdi_i,
   input  logic       drTdo_i,
   output logic       tdo_o,
   output logic       captureDR_o,
   output logic       shiftDR_o,
   output logic       updateDR_o,
   output logic       drEna_o,
   output logic [3:0] state_o
);

   tap_state_t              state;
   tap_state_t              state_next;
   logic [IDCODE_WIDTH-1:0] idcode_sr;
   logic                    bypass;
   logic [IR_WIDTH-1:0]     ir;
   logic                    ir_tdo;
   logic                    load_active;
   dr_sel_t                 dr_sel;

   always_ff @(posedge tck_i or posedge trst_i) begin
      if (trst_i) begin
         state <= TEST_LOGIC_RESET;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         TEST_LOGIC_RESET: state_next = tms_i ? TEST_LOGIC_RESET : RUN_IDLE;
         RUN_IDLE:         state_next = tms_i ? SELECT_DR        : RUN_IDLE;
         SELECT_DR:        state_next = tms_i ? SELECT_IR        : CAPTURE_DR;
         CAPTURE_DR:       state_next = tms_i ? EXIT1_DR         : SHIFT_DR;
         SHIFT_DR:         state_next = tms_i ? EXIT1_DR         : SHIFT_DR;
         EXIT1_DR:         state_next = tms_i ? UPDATE_DR        : PAUSE_DR;
         PAUSE_DR:         state_next = tms_i ? EXIT2_DR         : PAUSE_DR;
         EXIT2_DR:         state_next = tms_i ? UPDATE_DR        : SHIFT_DR;
         UPDATE_DR:        state_next = tms_i ? SELECT_DR        : RUN_IDLE;
         SELECT_IR:        state_next = tms_i ? TEST_LOGIC_RESET : CAPTURE_IR;
         CAPTURE_IR:       state_next = tms_i ? EXIT1_IR         : SHIFT_IR;
         SHIFT_IR:         state_next = tms_i ? EXIT1_IR         : SHIFT_IR;
         EXIT1_IR:         state_next = tms_i ? UPDATE_IR        : PAUSE_IR;
         PAUSE_IR:         state_next = tms_i ? EXIT2_IR         : PAUSE_IR;
         EXIT2_IR:         state_next = tms_i ? UPDATE_IR        : SHIFT_IR;
         UPDATE_IR:        state_next = tms_i ? SELECT_DR        : RUN_IDLE;
         default:          state_next = TEST_LOGIC_RESET;
      endcase
   end

   // Strobes are flopped from the next state, so each is high exactly while in its state.
   always_ff @(posedge tck_i or posedge trst_i) begin
      if (trst_i) begin
         captureDR_o <= 1'b0;
         shiftDR_o   <= 1'b0;
         updateDR_o  <= 1'b0;
      end else begin
         captureDR_o <= (state_next == CAPTURE_DR);
         shiftDR_o   <= (state_next == SHIFT_DR);
         updateDR_o  <= (state_next == UPDATE_DR);
      end
   end

   tap_ir u_ir (
      .tck_i       (tck_i),
      .trst_i      (trst_i),
      .state       (state),
      .tdi_i       (tdi_i),
      .ir          (ir),
      .ir_tdo      (ir_tdo),
      .load_active (load_active)
   );

   assign dr_sel = decode_ir(ir);

   // IDCODE and BYPASS data registers; only the one selected by ir moves.
   always_ff @(posedge tck_i or posedge trst_i) begin
      if (trst_i) begin
         idcode_sr <= '0;
         bypass    <= 1'b0;
      end else begin
         if (dr_sel == SEL_IDCODE) begin
            if (state == CAPTURE_DR) begin
               idcode_sr <= IDCODE_VALUE;
            end else if (state == SHIFT_DR) begin
               idcode_sr <= {tdi_i, idcode_sr[IDCODE_WIDTH-1:1]};
            end
         end
         if (dr_sel == SEL_BYPASS) begin
            if (state == CAPTURE_DR) begin
               bypass <= 1'b0;
            end else if (state == SHIFT_DR) begin
               bypass <= tdi_i;
            end
         end
      end
   end

   always_comb begin
      tdo_o = 1'b0;
      case (state)
         SHIFT_IR: tdo_o = ir_tdo;
         SHIFT_DR: begin
            case (dr_sel)
               SEL_LOAD:   tdo_o = drTdo_i;
               SEL_IDCODE: tdo_o = idcode_sr[0];
               default:    tdo_o = bypass;
            endcase
         end
         default: tdo_o = 1'b0;
      endcase
   end

   assign drEna_o = load_active;
   assign state_o = state;

endmodule
